// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds FSM/owner encodings, default widths and the burst-counter update rule.
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 4;
  localparam int BURST_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  // Re-grant to the same owner counts up and saturates; a switch restarts at 1.
  function automatic logic [BURST_W-1:0] burst_next(
    input logic [BURST_W-1:0] cur,
    input logic               same_owner,
    input logic [BURST_W-1:0] max_burst
  );
    if (!same_owner)
      return BURST_W'(1);
    else if (cur >= max_burst)
      return max_burst;
    else
      return cur + BURST_W'(1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle: valid/grant request plus done/read-data response.
// The requester drives through master, the arbiter answers through slave.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, done, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, done, rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way selector: round-robin between A and B, with an
// optional locked burst that keeps the previous owner for up to MAX_BURST grants.
module dmem_arbiter_rr_pick2
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic               req_a,
    input  logic               req_b,
    input  owner_t             last_owner,
    input  logic               lock_active,
    input  logic [BURST_W-1:0] burst_cnt,
    output logic               gnt_a,
    output logic               gnt_b
);

    logic keep_owner;

    assign keep_owner = lock_active && (burst_cnt < BURST_W'(MAX_BURST));

    always_comb begin
        // NOTE: both grants get a default before any branch so no path leaves them unassigned (no latch).
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && req_b) begin
            if (keep_owner) begin
                gnt_a = (last_owner == OWN_A);
                gnt_b = (last_owner == OWN_B);
            end else begin
                gnt_a = (last_owner == OWN_B);
                gnt_b = (last_owner == OWN_A);
            end
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between requester A (CPU) and B (DMA/debug).
// Each accepted request runs a fixed ACCESS then RESP sequence; memW/memR are registered.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     a,
    dmem_arbiter_if.slave     b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              memW,
    output logic              memR,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t             state;
    owner_t             owner;
    logic               lat_we;
    logic               lock_active;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [BURST_W-1:0] burst_cnt;
    logic               a_done_q;
    logic               b_done_q;
    logic [DATA_W-1:0]  a_rdata_q;
    logic [DATA_W-1:0]  b_rdata_q;

    logic               arb_en;
    logic               pick_a;
    logic               pick_b;
    logic               accept;
    owner_t             pick_owner;
    logic               pick_we;
    logic               pick_lock;
    logic [ADDR_W-1:0]  pick_addr;
    logic [DATA_W-1:0]  pick_wdata;

    // Arbitration is only open while no access is in flight on the memory.
    assign arb_en = (state == ST_IDLE) || (state == ST_RESP);

    dmem_arbiter_rr_pick2 #(
        .MAX_BURST (MAX_BURST)
    ) u_rr_pick2 (
        .req_a       (a.req && arb_en),
        .req_b       (b.req && arb_en),
        .last_owner  (owner),
        .lock_active (lock_active),
        .burst_cnt   (burst_cnt),
        .gnt_a       (pick_a),
        .gnt_b       (pick_b)
    );

    assign accept     = pick_a || pick_b;
    assign pick_owner = pick_b ? OWN_B : OWN_A;
    assign pick_we    = pick_b ? b.we    : a.we;
    assign pick_lock  = pick_b ? b.lock  : a.lock;
    assign pick_addr  = pick_b ? b.addr  : a.addr;
    assign pick_wdata = pick_b ? b.wdata : a.wdata;

    assign a.gnt   = pick_a;
    assign b.gnt   = pick_b;
    assign a.done  = a_done_q;
    assign b.done  = b_done_q;
    assign a.rdata = a_rdata_q;
    assign b.rdata = b_rdata_q;

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign busy      = (state != ST_IDLE);

    // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= OWN_B;
            lat_we      <= 1'b0;
            lock_active <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            burst_cnt   <= '0;
            memW        <= 1'b0;
            memR        <= 1'b0;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        owner       <= pick_owner;
                        lat_we      <= pick_we;
                        lock_active <= pick_lock;
                        lat_addr    <= pick_addr;
                        lat_wdata   <= pick_wdata;
                        burst_cnt   <= burst_next(burst_cnt, pick_owner == owner,
                                                  BURST_W'(MAX_BURST));
                        memW        <= pick_we;
                        memR        <= !pick_we;
                        state       <= ST_ACCESS;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Write commits and read data is captured at this closing edge.
                    memW <= 1'b0;
                    memR <= 1'b0;
                    if (owner == OWN_A) begin
                        a_done_q <= 1'b1;
                        if (!lat_we) a_rdata_q <= mem_rdata;
                    end else begin
                        b_done_q <= 1'b1;
                        if (!lat_we) b_rdata_q <= mem_rdata;
                    end
                    state <= ST_RESP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
